window3x3_gen: RTL and testbench
================================

# window3x3_gen

Builds the 3x3 neighbourhood window consumed by the per-pixel effect filters from a raster-order stream of 12-bit RGB444 pixels. It sits between the pixel source (frame buffer reader / camera) and any effect block, and produces the 108-bit packed `color_data` word and a qualifying strobe. Off-image neighbours are replaced by the nearest edge pixel, so every effect sees a full frame of W×H windows.

## Interface

- `IMG_W`, default 640: active pixels per line; must be at least 2.
- `IMG_H`, default 480: active lines per frame; must be at least 2.
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pix_in`  in  12  pixel as R[11:8], G[7:4], B[3:0].
- `pix_valid`  in  1  `pix_in` is valid.
- `pix_sof`  in  1  marks pixel (0,0) of a frame; qualified by `pix_valid`.
- `pix_ready`  out  1  block accepts a pixel this cycle.
- `color_data`  out  108  packed window; layout is given under Operation.
- `win_valid`  out  1  `color_data`, `win_x` and `win_y` are valid this cycle.
- `win_x`  out  clog2(IMG_W)  centre column.
- `win_y`  out  clog2(IMG_H)  centre row.
- `frame_done`  out  1  pulses together with the window at (IMG_W-1, IMG_H-1).

## Operation

- A pixel is accepted when `pix_valid & pix_ready`. Accepted pixels are numbered n = 0 .. W·H-1 in raster order.
- `color_data` packing, each field 12 bits:
  - original [107:96]
  - left [95:84]
  - right [83:72]
  - up [71:60]
  - down [59:48]
  - upleft [47:36]
  - upright [35:24]
  - downleft [23:12]
  - downright [11:0]
- Edge handling is clamp/replicate:
  - At x=0, the left-column fields take the x=0 pixel.
  - At x=W-1, the right-column fields take the x=W-1 pixel.
  - The same rule applies to rows at y=0 and y=H-1.
  - Corners clamp in both axes.
- Window k (centre at raster index k) is emitted once pixel k+W+1 has been accepted.
- Windows k > W·H-W-2 (the last W+1 windows) are generated in FLUSH without further input.
- FSM:
  - IDLE: `pix_ready`=1. Pixels without `pix_sof` are accepted and discarded. An accepted `pix_sof` pixel is stored as n=0 and the FSM moves to STREAM.
  - STREAM: `pix_ready`=1. Each accepted pixel with n ≥ W+1 emits one window. Acceptance of n = W·H-1 moves the FSM to FLUSH.
  - FLUSH: `pix_ready`=0. Emits one window per cycle for the remaining W+1 centres. After the last one, with `frame_done`, the FSM returns to IDLE.
- An accepted `pix_sof` in STREAM aborts the current frame: counters restart with this pixel as n=0, and no flush is performed for the aborted frame. In FLUSH, `pix_sof` is not accepted because `pix_ready` is 0.
- `pix_valid` low in STREAM stalls the block: no window is emitted and all state is held.
- Storage: two line buffers of W pixels plus a 3×3 tap register set. Clamping is done by muxing taps using the centre-coordinate counters.

## Timing

- Reset values:
  - `color_data`=0, `win_valid`=0, `frame_done`=0, `win_x`=0, `win_y`=0.
  - `pix_ready`=0 while `reset` is low, then 1 from the first clock after release. The FSM starts in IDLE.
- Latency: `win_valid` is asserted on the clock edge following acceptance of pixel k+W+1.
- Throughput: one window per accepted pixel in STREAM, and one per cycle in FLUSH.
- Per frame: exactly W·H windows are emitted, in raster centre order, with exactly one `frame_done`.
- There is no output backpressure. Downstream must accept every `win_valid` cycle.
- Reset asserted mid-frame clears all outputs immediately, asynchronously. Line buffer contents need not be cleared.

## Structure

- Shared package `effects_pkg`:
  - field LSB constants ORIG_LSB=96, LEFT_LSB=84, RIGHT_LSB=72, UP_LSB=60, DOWN_LSB=48, UL_LSB=36, UR_LSB=24, DL_LSB=12, DR_LSB=0
  - PIX_W=12
  - FSM state enum {IDLE, STREAM, FLUSH}
- One sub-module, `window_line_buffer`: a W-deep, 12-bit delay line with a shift enable. It is instantiated twice.

## Test plan

- W=4, H=3, pixel(x,y)=12'h0yx, continuous valid. Window (0,0) must appear 1 cycle after n=5 is accepted, with:
  - original=000, left=000, right=001, up=000, down=010
  - upleft=000, upright=001, downleft=010, downright=011
- Same stream, after n=11 is accepted: `pix_ready` must be 0 for 5 cycles while 5 FLUSH windows are emitted. The last window is (3,2), with `frame_done`=1 and:
  - original=023, left=022, right=023, up=013, down=023
  - upleft=012, upright=013, downleft=022, downright=023
- Random `pix_valid` gaps: the sequence of windows must be identical to the continuous case, and `win_valid` must never fire in a cycle without an accept, except during FLUSH.
- `pix_sof` reasserted at n=7: the old frame is dropped, and the next windows correspond to the new frame starting at (0,0) after its n=5.
- Non-sof pixels in IDLE: all are accepted and produce no output.
- `reset` pulled low during FLUSH: outputs go to 0 immediately. After release, the block is in IDLE with `pix_ready`=1 and a fresh frame processes correctly.

Source files
------------

// File: rtl/effects_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | effects_pkg                                                                |
// | Shared pixel/window constants and FSM state type for the effect pipeline.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package effects_pkg;

    localparam int PIX_W    = 12;
    localparam int WIN_W    = 9 * PIX_W;

    localparam int ORIG_LSB  = 96;
    localparam int LEFT_LSB  = 84;
    localparam int RIGHT_LSB = 72;
    localparam int UP_LSB    = 60;
    localparam int DOWN_LSB  = 48;
    localparam int UL_LSB    = 36;
    localparam int UR_LSB    = 24;
    localparam int DL_LSB    = 12;
    localparam int DR_LSB    = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } win_state_t;

endpackage
`default_nettype wire

// File: rtl/window_line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | window_line_buffer                                                         |
// | DEPTH-deep pixel delay line; dout is the pixel shifted in DEPTH shifts ago.|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module window_line_buffer
    import effects_pkg::*;
#(
    parameter int DEPTH = 640
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);

    localparam int            c_aw   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_aw-1:0] c_last = c_aw'(DEPTH - 1);

    logic [PIX_W-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (shift_en) begin
            r_ptr <= (r_ptr == c_last) ? '0 : r_ptr + 1'b1;
        end
    end

    // Circular RAM: the slot about to be overwritten holds the oldest pixel.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            r_mem[r_ptr] <= din;
        end
    end

    assign dout = r_mem[r_ptr];

endmodule
`default_nettype wire

// File: rtl/window3x3_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | window3x3_gen                                                              |
// | Raster pixel stream to clamped 3x3 neighbourhood windows, one per pixel.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module window3x3_gen
    import effects_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PIX_W-1:0]         pix_in,
    input  logic                     pix_valid,
    input  logic                     pix_sof,
    output logic                     pix_ready,
    output logic [WIN_W-1:0]         color_data,
    output logic                     win_valid,
    output logic [$clog2(IMG_W)-1:0] win_x,
    output logic [$clog2(IMG_H)-1:0] win_y,
    output logic                     frame_done
);

    localparam int              c_xw         = $clog2(IMG_W);
    localparam int              c_yw         = $clog2(IMG_H);
    localparam int              c_nw         = $clog2(IMG_W * IMG_H + 1);
    localparam logic [c_xw-1:0] c_x_last     = c_xw'(IMG_W - 1);
    localparam logic [c_yw-1:0] c_y_last     = c_yw'(IMG_H - 1);
    localparam logic [c_nw-1:0] c_first_emit = c_nw'(IMG_W + 1);
    localparam logic [c_nw-1:0] c_last_pix   = c_nw'(IMG_W * IMG_H - 1);

    win_state_t       r_state, w_state_next;
    logic             r_ready;
    logic [c_nw-1:0]  r_n;
    logic [c_xw-1:0]  r_x;
    logic [c_yw-1:0]  r_y;
    logic             w_accept, w_shift, w_emit, w_restart, w_last_win;
    logic             w_at_top, w_at_bot;
    logic [PIX_W-1:0] w_lb_near, w_lb_far;
    logic [PIX_W-1:0] r_col_l [3];
    logic [PIX_W-1:0] r_col_c [3];
    logic [PIX_W-1:0] w_col_r [3];
    logic [PIX_W-1:0] w_left  [3];
    logic [PIX_W-1:0] w_right [3];
    logic [WIN_W-1:0] w_win;

    assign pix_ready  = r_ready;
    assign w_accept   = pix_valid & r_ready;
    assign w_last_win = (r_x == c_x_last) && (r_y == c_y_last);
    assign w_at_top   = (r_y == '0);
    assign w_at_bot   = (r_y == c_y_last);

    window_line_buffer #(.DEPTH(IMG_W)) u_lb_near (
        .clk      (clk),
        .reset    (reset),
        .shift_en (w_shift),
        .din      (pix_in),
        .dout     (w_lb_near)
    );

    window_line_buffer #(.DEPTH(IMG_W)) u_lb_far (
        .clk      (clk),
        .reset    (reset),
        .shift_en (w_shift),
        .din      (w_lb_near),
        .dout     (w_lb_far)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ready <= (w_state_next != FLUSH);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_shift      = 1'b0;
        w_emit       = 1'b0;
        w_restart    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && pix_sof) begin
                    w_shift      = 1'b1;
                    w_restart    = 1'b1;
                    w_state_next = STREAM;
                end
            end
            STREAM: begin
                if (w_accept) begin
                    w_shift = 1'b1;
                    if (pix_sof) begin
                        w_restart = 1'b1;
                    end else begin
                        w_emit = (r_n >= c_first_emit);
                        if (r_n == c_last_pix) begin
                            w_state_next = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                // Input is ignored; shifting keeps the buffered rows advancing.
                w_shift = 1'b1;
                w_emit  = 1'b1;
                if (w_last_win) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_n <= '0;
            r_x <= '0;
            r_y <= '0;
        end else if (w_restart) begin
            r_n <= c_nw'(1);
            r_x <= '0;
            r_y <= '0;
        end else begin
            if (w_accept && (r_state == STREAM)) begin
                r_n <= r_n + 1'b1;
            end
            if (w_emit) begin
                if (r_x == c_x_last) begin
                    r_x <= '0;
                    r_y <= (r_y == c_y_last) ? '0 : r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
        end
    end

    // Incoming column is the right column of the window being emitted.
    always_comb begin
        w_col_r[0] = w_lb_far;
        w_col_r[1] = w_lb_near;
        w_col_r[2] = pix_in;
        for (int r = 0; r < 3; r++) begin
            w_left[r]  = (r_x == '0)      ? r_col_c[r] : r_col_l[r];
            w_right[r] = (r_x == c_x_last) ? r_col_c[r] : w_col_r[r];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col_l <= '{default: '0};
            r_col_c <= '{default: '0};
        end else if (w_shift) begin
            r_col_l <= r_col_c;
            r_col_c <= w_col_r;
        end
    end

    always_comb begin
        w_win = '0;
        w_win[ORIG_LSB  +: PIX_W] = r_col_c[1];
        w_win[LEFT_LSB  +: PIX_W] = w_left[1];
        w_win[RIGHT_LSB +: PIX_W] = w_right[1];
        w_win[UP_LSB    +: PIX_W] = w_at_top ? r_col_c[1] : r_col_c[0];
        w_win[DOWN_LSB  +: PIX_W] = w_at_bot ? r_col_c[1] : r_col_c[2];
        w_win[UL_LSB    +: PIX_W] = w_at_top ? w_left[1]  : w_left[0];
        w_win[UR_LSB    +: PIX_W] = w_at_top ? w_right[1] : w_right[0];
        w_win[DL_LSB    +: PIX_W] = w_at_bot ? w_left[1]  : w_left[2];
        w_win[DR_LSB    +: PIX_W] = w_at_bot ? w_right[1] : w_right[2];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            color_data <= '0;
            win_valid  <= 1'b0;
            win_x      <= '0;
            win_y      <= '0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= w_emit;
            frame_done <= w_emit & w_last_win;
            if (w_emit) begin
                color_data <= w_win;
                win_x      <= r_x;
                win_y      <= r_y;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_window3x3_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_window3x3_gen                                                           |
// | Directed table-driven bench for window3x3_gen on a 4x3 image.              |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_window3x3_gen;
    import effects_pkg::*;

    localparam int W = 4;
    localparam int H = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [11:0]  pix_in;
    logic         pix_valid;
    logic         pix_sof;
    logic         pix_ready;
    logic [107:0] color_data;
    logic         win_valid;
    logic [1:0]   win_x;
    logic [1:0]   win_y;
    logic         frame_done;

    window3x3_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_ready  (pix_ready),
        .color_data (color_data),
        .win_valid  (win_valid),
        .win_x      (win_x),
        .win_y      (win_y),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   x;
        logic [1:0]   y;
        logic [107:0] d;
    } exp_t;

    typedef struct {
        logic [1:0]   x;
        logic [1:0]   y;
        logic [107:0] d;
        logic         fd;
    } win_t;

    exp_t tbl [12];
    win_t wq [$];
    int   errors = 0;
    int   checks = 0;
    int   bad_strobe = 0;
    logic acc_q = 1'b0;
    logic rdy_q = 1'b0;

    always @(posedge clk) begin
        acc_q <= pix_valid && pix_ready;
        rdy_q <= pix_ready;
    end

    always @(negedge clk) begin
        if (win_valid) begin
            wq.push_back('{win_x, win_y, color_data, frame_done});
            if (!acc_q && rdy_q) bad_strobe++;
        end
    end

    function automatic logic [107:0] w9(input logic [11:0] o, l, r, u, d, ul, ur, dl, dr);
        return {o, l, r, u, d, ul, ur, dl, dr};
    endfunction

    function automatic logic [11:0] pix(input int n);
        logic [3:0] x;
        logic [3:0] y;
        x = 4'(n % W);
        y = 4'(n / W);
        return {4'h0, y, x};
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic send(input logic [11:0] p, input logic sof, input int gap);
        int t;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        repeat (gap) @(negedge clk);
        pix_in    = p;
        pix_valid = 1'b1;
        pix_sof   = sof;
        t = 0;
        while (!pix_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!pix_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: pix_ready got 0 expected 1");
        end
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [11:0] offs, input int gapmax);
        for (int n = 0; n < W * H; n++) begin
            send(pix(n) | offs, (n == 0), (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
        end
    endtask

    task automatic check_frame(input string name, input int base);
        chk({name, "_count"}, wq.size(), base + W * H);
        for (int i = 0; i < W * H; i++) begin
            if (base + i < wq.size()) begin
                chk($sformatf("%s_win%0d", name, i),
                    {wq[base+i].fd, wq[base+i].x, wq[base+i].y, wq[base+i].d},
                    {(i == W * H - 1), tbl[i].x, tbl[i].y, tbl[i].d});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lowc;
        int bs0;

        tbl[0].d  = w9(12'h000, 12'h000, 12'h001, 12'h000, 12'h010, 12'h000, 12'h001, 12'h010, 12'h011);
        tbl[1].d  = w9(12'h001, 12'h000, 12'h002, 12'h001, 12'h011, 12'h000, 12'h002, 12'h010, 12'h012);
        tbl[2].d  = w9(12'h002, 12'h001, 12'h003, 12'h002, 12'h012, 12'h001, 12'h003, 12'h011, 12'h013);
        tbl[3].d  = w9(12'h003, 12'h002, 12'h003, 12'h003, 12'h013, 12'h002, 12'h003, 12'h012, 12'h013);
        tbl[4].d  = w9(12'h010, 12'h010, 12'h011, 12'h000, 12'h020, 12'h000, 12'h001, 12'h020, 12'h021);
        tbl[5].d  = w9(12'h011, 12'h010, 12'h012, 12'h001, 12'h021, 12'h000, 12'h002, 12'h020, 12'h022);
        tbl[6].d  = w9(12'h012, 12'h011, 12'h013, 12'h002, 12'h022, 12'h001, 12'h003, 12'h021, 12'h023);
        tbl[7].d  = w9(12'h013, 12'h012, 12'h013, 12'h003, 12'h023, 12'h002, 12'h003, 12'h022, 12'h023);
        tbl[8].d  = w9(12'h020, 12'h020, 12'h021, 12'h010, 12'h020, 12'h010, 12'h011, 12'h020, 12'h021);
        tbl[9].d  = w9(12'h021, 12'h020, 12'h022, 12'h011, 12'h021, 12'h010, 12'h012, 12'h020, 12'h022);
        tbl[10].d = w9(12'h022, 12'h021, 12'h023, 12'h012, 12'h022, 12'h011, 12'h013, 12'h021, 12'h023);
        tbl[11].d = w9(12'h023, 12'h022, 12'h023, 12'h013, 12'h023, 12'h012, 12'h013, 12'h022, 12'h023);
        for (int i = 0; i < W * H; i++) begin
            tbl[i].x = 2'(i % W);
            tbl[i].y = 2'(i / W);
        end

        reset     = 1'b0;
        pix_in    = '0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {win_valid, frame_done, win_x, win_y, color_data}, '0);
        chk("reset_ready", pix_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_release", pix_ready, 1);

        // Non-sof pixels in IDLE are swallowed without output.
        for (int i = 0; i < 5; i++) send(12'hA00 + 12'(i), 1'b0, 0);
        repeat (10) @(negedge clk);
        chk("idle_no_windows", wq.size(), 0);

        // Continuous frame: first-window latency and flush length.
        bs0 = bad_strobe;
        for (int n = 0; n < W * H; n++) begin
            send(pix(n), (n == 0), 0);
            if (n == 4) chk("no_window_before_n5", win_valid, 0);
            if (n == 5) chk("first_window_latency", {win_valid, win_x, win_y, color_data},
                            {1'b1, 2'd0, 2'd0, tbl[0].d});
        end
        lowc = 0;
        while (!pix_ready && lowc < 20) begin
            lowc++;
            @(negedge clk);
        end
        chk("flush_ready_low_cycles", lowc, 5);
        chk("frame_done_last", {frame_done, win_valid, win_x, win_y, color_data},
            {1'b1, 1'b1, 2'd3, 2'd2, tbl[11].d});
        repeat (5) @(negedge clk);
        check_frame("cont", 0);
        chk("cont_strobe_without_accept", bad_strobe - bs0, 0);

        // Random input gaps must not change the window sequence.
        wq.delete();
        bs0 = bad_strobe;
        send_frame(12'h000, 3);
        repeat (12) @(negedge clk);
        check_frame("gaps", 0);
        chk("gaps_strobe_without_accept", bad_strobe - bs0, 0);

        // sof at n=7 aborts the first frame after its first two windows.
        wq.delete();
        for (int n = 0; n < 7; n++) send(pix(n) | 12'h500, (n == 0), 0);
        send_frame(12'h000, 0);
        repeat (12) @(negedge clk);
        if (wq.size() >= 2) begin
            chk("abort_old_coords", {wq[0].x, wq[0].y, wq[1].x, wq[1].y}, {2'd0, 2'd0, 2'd1, 2'd0});
        end
        check_frame("abort", 2);

        // Reset asserted mid-flush clears outputs without a clock edge.
        wq.delete();
        send_frame(12'h000, 0);
        @(negedge clk);
        #1 reset = 1'b0;
        #1 chk("reset_async_clears", {win_valid, frame_done, win_x, win_y, color_data, pix_ready}, '0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_midflush_reset", pix_ready, 1);
        wq.delete();
        send_frame(12'h000, 0);
        repeat (12) @(negedge clk);
        check_frame("after_reset", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
